wall_probe: RTL
===============

# wall_probe

Collision probe engine that scans the wall geometry around Mario once per frame. On a start pulse it latches Mario's bounding box and the current room, then issues eight sequential point queries to a combinational wall-lookup instance. The lookup is the same room tile map the color mapper uses, instantiated separately and driven from `query_x`/`query_y`/`query_room`. The engine folds the `query_hit` answers into four directional blocked flags plus a fell-out flag, which the Mario motion logic consumes.

## Interface
- `MARIO_W`, default 20: bounding-box width in pixels.
- `MARIO_H`, default 20: bounding-box height in pixels.
- `SCREEN_W`, default 640: horizontal playfield limit.
- `SCREEN_H`, default 480: vertical playfield limit.
- `Clk` input 1: the single clock.
- `Reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle request, sampled only in IDLE.
- `MarioX` input 10: bounding-box top-left X.
- `MarioY` input 10: bounding-box top-left Y.
- `RoomNum` input 2: current level.
- `query_x` output 10: probe pixel X, to the lookup's DrawX.
- `query_y` output 10: probe pixel Y, to the lookup's DrawY.
- `query_room` output 2: latched room, to the lookup's RoomNum.
- `query_hit` input 1: is_wall from the lookup; combinational on the current query.
- `busy` output 1: high while probing.
- `done` output 1: one-cycle pulse when results update.
- `blocked_down`, `blocked_up`, `blocked_left`, `blocked_right` output 1 each: registered result flags.
- `fell_out` output 1: box bottom at or past `SCREEN_H`.

## Operation
- FSM states: IDLE, PROBE, FINISH.
- IDLE to PROBE: on `start`. Latch X, Y and room, clear the internal accumulators, set `idx`=0.
- PROBE: one probe per cycle, `idx` 0..7.
  - After `idx`=7, go to FINISH.
- FINISH: copy the accumulators to the output flags, pulse `done`, return to IDLE.
- Probe points (X, Y latched):
  - 0: (X, Y+H)
  - 1: (X+W-1, Y+H)
  - 2: (X, Y-1)
  - 3: (X+W-1, Y-1)
  - 4: (X-1, Y)
  - 5: (X-1, Y+H-1)
  - 6: (X+W, Y)
  - 7: (X+W, Y+H-1)
- Flag mapping:
  - down = hit0 | hit1
  - up = hit2 | hit3
  - left = hit4 | hit5
  - right = hit6 | hit7
- Arithmetic: all probe coordinates are computed at 11 bits signed. A probe is out of range if its X < 0, X ≥ `SCREEN_W`, Y < 0 or Y ≥ `SCREEN_H`.
- Out-of-range rules:
  - Out-of-range probes 2..7 count as a hit, regardless of `query_hit`.
  - Probes 0/1 with Y+H ≥ `SCREEN_H` count as a miss and set the fell-out accumulator.
  - Probes 0/1 whose only fault is X out of range count as a hit.
- Query outputs carry the low 10 bits of the probe coordinate even when out of range. The lookup answer is ignored in that case.
- `start` while busy or in FINISH is ignored; it is not queued.
- `RoomNum`/`MarioX`/`MarioY` changes after the latch have no effect until the next start.

## Timing
- Reset values:
  - all flags 0, `fell_out` 0
  - `busy` 0, `done` 0
  - `query_x`/`query_y`/`query_room` 0
  - state IDLE
- `start` high at edge N.
  - Probe i is presented on the query outputs (registered) during cycle N+1+i, i = 0..7.
  - `query_hit` is sampled at the end of that same cycle.
- `busy` is high for cycles N+1..N+8.
- FINISH occupies cycle N+9:
  - `done` is high for that single cycle.
  - The new flags are visible in the same cycle and held until the next FINISH.
- Latency: start to done is 9 cycles. The earliest accepted restart is `start` at N+10.
- Query outputs return to 0 in IDLE and FINISH.
- Reset mid-probe returns to IDLE next edge. Flags are cleared, no `done` pulse, partial results are discarded.
- Reset and `start` in the same cycle: Reset wins.

## Test plan
- Room 1, X=40, Y=420, W=H=20, pulse start → `done` at start+9; down=1, up=0, left=0, right=0, `fell_out`=0; `busy` high exactly 8 cycles.
- Room 1, X=220, Y=420 (over the ground gap at X 200..259) → down=0 and the other flags 0. Then Y=460 → `fell_out`=1, down=0.
- Room 1, X=160, Y=180 (directly under the brick at 160,160) → up=1; probe 2 presented as (160,179) during cycle start+3.
- Room 1, X=20, Y=100 → left=1 (border column). Then X=0 → left=1 with `query_x`=1023 on probes 4/5 and `query_hit` forced 0 by the bench; the flag is still 1.
- Room 0, X=620, Y=200 → right=1 (X+W=640 is out of range); `query_room`=0 throughout.
- Second start pulsed at start+4 is ignored (exactly one `done`). Reset asserted at start+5 → no `done`, all flags 0, `busy` 0 next cycle.

Source files
------------

// File: rtl/wall_probe.sv
// rtl/wall_probe.sv - eight-point wall probe around Mario's box, folded into directional blocked flags
// One probe per cycle against an external combinational wall lookup; results publish on a done pulse.
module wall_probe #(
    parameter int MARIO_W  = 20,
    parameter int MARIO_H  = 20,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [9:0] MarioX,
    input  logic [9:0] MarioY,
    input  logic [1:0] RoomNum,
    output logic [9:0] query_x,
    output logic [9:0] query_y,
    output logic [1:0] query_room,
    input  logic       query_hit,
    output logic       busy,
    output logic       done,
    output logic       blocked_down,
    output logic       blocked_up,
    output logic       blocked_left,
    output logic       blocked_right,
    output logic       fell_out
);

    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_FINISH} state_t;

    localparam logic signed [10:0] W11  = 11'(MARIO_W);
    localparam logic signed [10:0] H11  = 11'(MARIO_H);
    localparam logic signed [10:0] SW11 = 11'(SCREEN_W);
    localparam logic signed [10:0] SH11 = 11'(SCREEN_H);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  qx_q, qx_d, qy_q, qy_d;
    logic [1:0]  qroom_q, qroom_d;
    logic [3:0]  acc_q, acc_d;      // {right, left, up, down}
    logic        fell_acc_q, fell_acc_d;
    logic [3:0]  flags_q, flags_d;
    logic        fell_q, fell_d;

    // Returns {px, py} as 11-bit signed coordinates for probe i of the box at (bx, by).
    function automatic logic [21:0] probe_xy(input logic [9:0] bx, input logic [9:0] by,
                                             input logic [2:0] i);
        logic signed [10:0] x0, y0, px, py;
        x0 = signed'({1'b0, bx});
        y0 = signed'({1'b0, by});
        px = x0;
        py = y0;
        case (i)
            3'd0:    py = y0 + H11;
            3'd1:    begin px = x0 + W11 - 11'sd1; py = y0 + H11; end
            3'd2:    py = y0 - 11'sd1;
            3'd3:    begin px = x0 + W11 - 11'sd1; py = y0 - 11'sd1; end
            3'd4:    px = x0 - 11'sd1;
            3'd5:    begin px = x0 - 11'sd1; py = y0 + H11 - 11'sd1; end
            3'd6:    px = x0 + W11;
            default: begin px = x0 + W11; py = y0 + H11 - 11'sd1; end
        endcase
        return {px, py};
    endfunction

    logic [21:0]        cur_xy, nxt_xy, start_xy;
    logic signed [10:0] cur_px, cur_py;
    logic               x_oor, y_lo, y_hi, probe_hit, probe_fell;

    assign cur_xy   = probe_xy(x_q, y_q, idx_q);
    assign nxt_xy   = probe_xy(x_q, y_q, idx_q + 3'd1);
    assign start_xy = probe_xy(MarioX, MarioY, 3'd0);
    assign cur_px   = signed'(cur_xy[21:11]);
    assign cur_py   = signed'(cur_xy[10:0]);
    assign x_oor    = (cur_px < 11'sd0) || (cur_px >= SW11);
    assign y_lo     = cur_py < 11'sd0;
    assign y_hi     = cur_py >= SH11;

    // Floor probes past the bottom edge are a miss that marks falling out; any other
    // off-screen probe is treated as solid wall.
    always_comb begin
        probe_hit  = query_hit;
        probe_fell = 1'b0;
        if (idx_q[2:1] == 2'd0 && y_hi) begin
            probe_hit  = 1'b0;
            probe_fell = 1'b1;
        end else if (x_oor || y_lo || y_hi) begin
            probe_hit = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x_d        = x_q;
        y_d        = y_q;
        qx_d       = 10'd0;
        qy_d       = 10'd0;
        qroom_d    = 2'd0;
        acc_d      = acc_q;
        fell_acc_d = fell_acc_q;
        flags_d    = flags_q;
        fell_d     = fell_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_PROBE;
                    x_d        = MarioX;
                    y_d        = MarioY;
                    idx_d      = 3'd0;
                    acc_d      = 4'd0;
                    fell_acc_d = 1'b0;
                    qx_d       = start_xy[20:11];
                    qy_d       = start_xy[9:0];
                    qroom_d    = RoomNum;
                end
            end
            S_PROBE: begin
                acc_d[idx_q[2:1]] = acc_q[idx_q[2:1]] | probe_hit;
                fell_acc_d        = fell_acc_q | probe_fell;
                if (idx_q == 3'd7) begin
                    state_d = S_FINISH;
                    flags_d = acc_d;
                    fell_d  = fell_acc_d;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    qx_d    = nxt_xy[20:11];
                    qy_d    = nxt_xy[9:0];
                    qroom_d = qroom_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            qx_q       <= 10'd0;
            qy_q       <= 10'd0;
            qroom_q    <= 2'd0;
            acc_q      <= 4'd0;
            fell_acc_q <= 1'b0;
            flags_q    <= 4'd0;
            fell_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            y_q        <= y_d;
            qx_q       <= qx_d;
            qy_q       <= qy_d;
            qroom_q    <= qroom_d;
            acc_q      <= acc_d;
            fell_acc_q <= fell_acc_d;
            flags_q    <= flags_d;
            fell_q     <= fell_d;
        end
    end

    assign query_x       = qx_q;
    assign query_y       = qy_q;
    assign query_room    = qroom_q;
    assign busy          = (state_q == S_PROBE);
    assign done          = (state_q == S_FINISH);
    assign blocked_down  = flags_q[0];
    assign blocked_up    = flags_q[1];
    assign blocked_left  = flags_q[2];
    assign blocked_right = flags_q[3];
    assign fell_out      = fell_q;

endmodule
